// File: rtl/morse_rx_decoder.sv
// morse_rx_decoder: Morse receiver. Synchronizes a keyed on/off line and times marks and
// spaces in whole units. Each mark is classified as a dot or a dash. One ASCII character
// is emitted per letter, and one pulse is emitted per word gap.
// Optional feature macro: SOS_DETECT_EN (adds an S,O,S detector that pulses oSOS).
module morse_rx_decoder #(
    parameter int CLK_PER_UNIT = 12500000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iKEY,
    output logic [7:0] oCHAR,
    output logic       oVALID,
    output logic       oWORD,
    output logic       oSOS
);

    localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;

    typedef enum logic [1:0] {IDLE, MARK, GAP, WGAP} state_t;

    logic          keyMeta_q, keySync_q;
    logic          keyEdge, keyRise, keyFall;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    units_q, units_d, unitsInc, markUnits;
    logic          unitWrap, isDash;
    logic          emitChar, emitWord;
    state_t        state_q;
    logic [4:0]    bits_q;
    logic [2:0]    len_q;
    logic          ovf_q;
    logic [7:0]    char_q, charLookup;
    logic          valid_q, word_q;

    // Pattern to ASCII: the last len symbols of bits (dash = 1, first symbol most significant)
    function automatic logic [7:0] lookupChar(input logic [2:0] len, input logic [4:0] bits);
        logic [7:0] c;
        case ({len, bits})
            {3'd1, 5'b00000}: c = 8'h45; {3'd1, 5'b00001}: c = 8'h54;
            {3'd2, 5'b00000}: c = 8'h49; {3'd2, 5'b00001}: c = 8'h41;
            {3'd2, 5'b00010}: c = 8'h4E; {3'd2, 5'b00011}: c = 8'h4D;
            {3'd3, 5'b00000}: c = 8'h53; {3'd3, 5'b00001}: c = 8'h55;
            {3'd3, 5'b00010}: c = 8'h52; {3'd3, 5'b00011}: c = 8'h57;
            {3'd3, 5'b00100}: c = 8'h44; {3'd3, 5'b00101}: c = 8'h4B;
            {3'd3, 5'b00110}: c = 8'h47; {3'd3, 5'b00111}: c = 8'h4F;
            {3'd4, 5'b00000}: c = 8'h48; {3'd4, 5'b00001}: c = 8'h56;
            {3'd4, 5'b00010}: c = 8'h46; {3'd4, 5'b00100}: c = 8'h4C;
            {3'd4, 5'b00110}: c = 8'h50; {3'd4, 5'b00111}: c = 8'h4A;
            {3'd4, 5'b01000}: c = 8'h42; {3'd4, 5'b01001}: c = 8'h58;
            {3'd4, 5'b01010}: c = 8'h43; {3'd4, 5'b01011}: c = 8'h59;
            {3'd4, 5'b01100}: c = 8'h5A; {3'd4, 5'b01101}: c = 8'h51;
            {3'd5, 5'b01111}: c = 8'h31; {3'd5, 5'b00111}: c = 8'h32;
            {3'd5, 5'b00011}: c = 8'h33; {3'd5, 5'b00001}: c = 8'h34;
            {3'd5, 5'b00000}: c = 8'h35; {3'd5, 5'b10000}: c = 8'h36;
            {3'd5, 5'b11000}: c = 8'h37; {3'd5, 5'b11100}: c = 8'h38;
            {3'd5, 5'b11110}: c = 8'h39; {3'd5, 5'b11111}: c = 8'h30;
            default:          c = 8'h3F;
        endcase
        return c;
    endfunction

    // An edge is seen while the synchronized value is about to change, so the counters
    // clear in the same cycle that kS takes its new level
    assign keyEdge  = keyMeta_q ^ keySync_q;
    assign keyRise  = keyEdge & keyMeta_q;
    assign keyFall  = keyEdge & ~keyMeta_q;
    assign unitWrap = (presc_q == PW'(CLK_PER_UNIT - 1));
    assign unitsInc = (units_q == 3'd7) ? units_q : units_q + 3'd1;

    // A mark that ends exactly on a unit boundary gets credit for that final unit
    assign markUnits  = unitWrap ? unitsInc : units_q;
    assign isDash     = (markUnits >= 3'd2);
    assign emitChar   = (state_q == GAP)  && !keyRise && unitWrap && (units_q == 3'd1);
    assign emitWord   = (state_q == WGAP) && !keyRise && unitWrap && (units_q == 3'd4);
    assign charLookup = ovf_q ? 8'h3F : lookupChar(len_q, bits_q);

    // Two-flop synchronizer for the asynchronous key line
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            keyMeta_q <= 1'b0;
            keySync_q <= 1'b0;
        end else begin
            keyMeta_q <= iKEY;
            keySync_q <= keyMeta_q;
        end
    end

    // Next-state prescaler and unit counter; a key edge wins over a simultaneous wrap
    always_comb begin
        presc_d = presc_q + PW'(1);
        units_d = units_q;
        if (keyEdge) begin
            presc_d = '0;
            units_d = '0;
        end else if (unitWrap) begin
            presc_d = '0;
            units_d = unitsInc;
        end
    end

    // Prescaler and saturating unit counter registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            presc_q <= '0;
            units_q <= '0;
        end else begin
            presc_q <= presc_d;
            units_q <= units_d;
        end
    end

    // Letter FSM with symbol buffer and registered character/word outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            bits_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            word_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (keyRise) state_q <= MARK;
                end
                MARK: begin
                    if (keyFall) begin
                        if (len_q == 3'd5) begin
                            ovf_q <= 1'b1;
                        end else begin
                            bits_q <= {bits_q[3:0], isDash};
                            len_q  <= len_q + 3'd1;
                        end
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (keyRise) begin
                        state_q <= MARK;
                    end else if (emitChar) begin
                        valid_q <= 1'b1;
                        char_q  <= charLookup;
                        bits_q  <= '0;
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= WGAP;
                    end
                end
                WGAP: begin
                    if (keyRise) begin
                        state_q <= MARK;
                    end else if (emitWord) begin
                        word_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oCHAR  = char_q;
    assign oVALID = valid_q;
    assign oWORD  = word_q;

`ifdef SOS_DETECT_EN
    logic [7:0] histOld_q, histNew_q;
    logic       sos_q;

    // Two-character history within the current word; pulses when S follows "SO"
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            histOld_q <= 8'h00;
            histNew_q <= 8'h00;
            sos_q     <= 1'b0;
        end else begin
            sos_q <= 1'b0;
            if (emitWord) begin
                histOld_q <= 8'h00;
                histNew_q <= 8'h00;
            end else if (emitChar) begin
                sos_q     <= (charLookup == 8'h53) && (histOld_q == 8'h53) && (histNew_q == 8'h4F);
                histOld_q <= histNew_q;
                histNew_q <= charLookup;
            end
        end
    end

    assign oSOS = sos_q;
`else
    assign oSOS = 1'b0;
`endif

endmodule

// File: tb/tb_morse_rx_decoder.sv
// tb_morse_rx_decoder: directed bench for the Morse receiver with a 10-cycle unit.
`timescale 1ns/1ps
module tb_morse_rx_decoder;

    localparam int UNIT = 10;
`ifdef SOS_DETECT_EN
    localparam int EXP_SOS    = 1;
    localparam int EXP_SOS_AT = 3;
`else
    localparam int EXP_SOS    = 0;
    localparam int EXP_SOS_AT = 0;
`endif

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iKEY = 1'b0;
    logic [7:0] oCHAR;
    logic       oVALID, oWORD, oSOS;

    int         cycleCount = 0;
    int         validCount, wordCount, sosCount, sosAtValid, lastValidCycle;
    logic [7:0] chars[$];
    int         checkCount = 0;
    int         passCount = 0;
    int         fallCycle;

    morse_rx_decoder #(.CLK_PER_UNIT(UNIT)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iKEY   (iKEY),
        .oCHAR  (oCHAR),
        .oVALID (oVALID),
        .oWORD  (oWORD),
        .oSOS   (oSOS)
    );

    // 10 ns clock
    always #5 iCLK = ~iCLK;

    // Cycle counter used for latency measurement
    always @(posedge iCLK) cycleCount <= cycleCount + 1;

    // Output monitor, sampling on the falling edge
    always @(negedge iCLK) begin
        if (oVALID) begin
            validCount++;
            chars.push_back(oCHAR);
            lastValidCycle = cycleCount;
        end
        if (oWORD) wordCount++;
        if (oSOS) begin
            sosCount++;
            sosAtValid = oVALID ? validCount : -1;
        end
    end

    task automatic clearCounts();
        validCount = 0;
        wordCount  = 0;
        sosCount   = 0;
        sosAtValid = 0;
        chars.delete();
    endtask

    function automatic logic [7:0] charAt(input int idx);
        if (idx < chars.size()) return chars[idx];
        return 8'hxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Hold the key at a level for a number of cycles; drives land 1 ns after a rising edge
    task automatic applyStimulus(input logic level, input int cycles);
        iKEY = level;
        repeat (cycles) @(posedge iCLK);
        #1;
    endtask

    // Key one letter with 1-unit dots, 3-unit dashes and 1-unit inner spaces; ends with key high
    task automatic sendLetter(input string code);
        for (int i = 0; i < code.len(); i++) begin
            applyStimulus(1'b1, (code[i] == "-") ? 3 * UNIT : UNIT);
            if (i != code.len() - 1) applyStimulus(1'b0, UNIT);
        end
    endtask

    initial begin
        clearCounts();
        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("reset_char",  oCHAR,  8'h00);
        checkOutput("reset_valid", oVALID, 1'b0);
        checkOutput("reset_word",  oWORD,  1'b0);
        checkOutput("reset_sos",   oSOS,   1'b0);
        iRST_N = 1'b1;
        applyStimulus(1'b0, 5);

        // 1: ".-" -> 'A' with 22-cycle latency
        clearCounts();
        sendLetter(".-");
        fallCycle = cycleCount;
        applyStimulus(1'b0, 3 * UNIT);
        checkOutput("t1_valid_count", validCount, 1);
        checkOutput("t1_char",        charAt(0), 8'h41);
        checkOutput("t1_latency",     lastValidCycle - fallCycle, 22);
        checkOutput("t1_no_word_yet", wordCount, 0);
        applyStimulus(1'b0, 5 * UNIT);
        checkOutput("t1_word",        wordCount, 1);
        checkOutput("t1_char_held",   oCHAR, 8'h41);

        // 2: S,O,S in one word
        clearCounts();
        sendLetter("...");
        applyStimulus(1'b0, 3 * UNIT);
        sendLetter("---");
        applyStimulus(1'b0, 3 * UNIT);
        sendLetter("...");
        applyStimulus(1'b0, 7 * UNIT);
        checkOutput("t2_valid_count", validCount, 3);
        checkOutput("t2_char0",       charAt(0), 8'h53);
        checkOutput("t2_char1",       charAt(1), 8'h4F);
        checkOutput("t2_char2",       charAt(2), 8'h53);
        checkOutput("t2_word",        wordCount, 1);
        checkOutput("t2_sos_count",   sosCount, EXP_SOS);
        checkOutput("t2_sos_at",      sosAtValid, EXP_SOS_AT);

        // 3: overflow, unassigned pattern, a digit and a 4-symbol letter
        clearCounts();
        sendLetter("......");
        applyStimulus(1'b0, 3 * UNIT);
        sendLetter("..--");
        applyStimulus(1'b0, 3 * UNIT);
        sendLetter("....-");
        applyStimulus(1'b0, 3 * UNIT);
        sendLetter("--..");
        applyStimulus(1'b0, 7 * UNIT);
        checkOutput("t3_valid_count", validCount, 4);
        checkOutput("t3_overflow",    charAt(0), 8'h3F);
        checkOutput("t3_unassigned",  charAt(1), 8'h3F);
        checkOutput("t3_digit4",      charAt(2), 8'h34);
        checkOutput("t3_letterZ",     charAt(3), 8'h5A);
        checkOutput("t3_word",        wordCount, 1);

        // 4: 12-unit mark then long space
        clearCounts();
        applyStimulus(1'b1, 12 * UNIT);
        applyStimulus(1'b0, 10 * UNIT);
        checkOutput("t4_valid_count", validCount, 1);
        checkOutput("t4_char",        charAt(0), 8'h54);
        checkOutput("t4_word",        wordCount, 1);
        applyStimulus(1'b0, 10 * UNIT);
        checkOutput("t4_no_more_valid", validCount, 1);
        checkOutput("t4_no_more_word",  wordCount, 1);

        // 5: reset mid-letter
        clearCounts();
        sendLetter("..");
        applyStimulus(1'b0, 5);
        iRST_N = 1'b0;
        applyStimulus(1'b0, 3);
        checkOutput("t5_rst_char",  oCHAR,  8'h00);
        checkOutput("t5_rst_valid", oVALID, 1'b0);
        checkOutput("t5_rst_word",  oWORD,  1'b0);
        iRST_N = 1'b1;
        applyStimulus(1'b0, 2 * UNIT);
        sendLetter("-");
        applyStimulus(1'b0, 7 * UNIT);
        checkOutput("t5_valid_count", validCount, 1);
        checkOutput("t5_char",        charAt(0), 8'h54);
        checkOutput("t5_word",        wordCount, 1);

        // 6: 1.9-unit mark is a dot, 2.0-unit mark is a dash, 1.9-unit space stays in the letter
        clearCounts();
        applyStimulus(1'b1, 19);
        applyStimulus(1'b0, 19);
        applyStimulus(1'b1, 20);
        checkOutput("t6_no_valid_mid", validCount, 0);
        applyStimulus(1'b0, 7 * UNIT);
        checkOutput("t6_valid_count", validCount, 1);
        checkOutput("t6_char",        charAt(0), 8'h41);
        checkOutput("t6_word",        wordCount, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
